sha3_msg_feeder: RTL and testbench
==================================

SHA3_MSG_FEEDER -- requirements
Module: sha3_msg_feeder

Interface
REQ-001 SHALL have parameter SHA3_BITLEN, default 11, width of core block-length field.
REQ-002 SHALL have ports: clk  in  1  system clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have cmd_valid_i in 1, cmd_ready_o out 1, mode_sel_i in 3 (0 shake128, 1 shake256, 2 sha3512, 3 sha3384, 4 sha3256, 5 sha3224), msg_bitlen_i in 21 (total message bits).
REQ-004 SHALL have s_valid_i in 1, s_ready_o out 1, s_data_i in 64 [0:63] (message words, bit 0 first, left-justified).
REQ-005 SHALL have core-side ports: mode_sel_o out 3, din64_o out 64 [0:63], din_valid_o out 1, bitlen_o out SHA3_BITLEN, hash_ready_o out 1, start_o out 1, flag_o out 1, core_ready_i in 1, valid_32_i in 1.
REQ-006 SHALL have done_o out 1: one-cycle pulse at end of message.

Function
REQ-007 SHALL accept a command on cmd_valid_i&cmd_ready_o; cmd_ready_o=1 only in IDLE; mode and length latched.
REQ-008 SHALL map rate RATE (bits) / words W: mode 0 1344/21, 1 1088/17, 2 576/9, 3 832/13, 4 1088/17, 5 1152/18, 6-7 1088/17.
REQ-009 SHALL split the message into floor(L/RATE) full blocks (bitlen_o=RATE) followed by exactly one final block (bitlen_o=L mod RATE, may be 0).
REQ-010 SHALL consume exactly ceil(L/64) stream words per message; s_ready_o=1 only in LOAD while stream words remain.
REQ-011 In LOAD, SHALL assert din_valid_o for exactly W cycles per block, with din64_o valid on each; a stream word is presented only on its handshake cycle; once stream words are exhausted, zero words are presented without stalling.
REQ-012 SHALL zero bits of the last stream word at positions >= (L mod 64) when L mod 64 != 0.
REQ-013 SHALL hold din_valid_o=0 on cycles where a stream word is needed and s_valid_i=0 (stall; word count does not advance).
REQ-014 SHALL implement FSM IDLE -> LOAD -> ARM -> START -> BUSY -> (LOAD | WAIT_OUT) -> IDLE.
REQ-015 LOAD: hash_ready_o=0; after W-th word -> ARM.
REQ-016 ARM: hash_ready_o=1; when core_ready_i=1, start_o=1 next cycle and -> START.
REQ-017 START: start_o=1 until core_ready_i=0 sampled, then start_o=0, flag_o=1 -> BUSY.
REQ-018 BUSY: flag_o=1 until core_ready_i=1 sampled; next cycle flag_o=0, hash_ready_o=0; -> LOAD if more blocks, else WAIT_OUT.
REQ-019 WAIT_OUT: on valid_32_i=1, done_o=1 for one cycle -> IDLE.
REQ-020 bitlen_o and mode_sel_o SHALL be stable from LOAD entry of a block through BUSY exit.
REQ-021 Remaining-bit counter SHALL be 21 bits, decrement by RATE per full block, no wrap (L < RATE handled as final block).

Reset
REQ-022 reset SHALL, on any clock edge, force IDLE and all outputs to 0 except cmd_ready_o=1 next cycle, including mid-LOAD or mid-BUSY; partially fed blocks are discarded.
REQ-023 cmd_valid_i during reset cycle SHALL be ignored.

Structure
REQ-024 Rate/word-count table, mode encodings and SHA3_BITLEN default SHALL live in shared package sha3_pkg.
REQ-025 One sub-module sha3_rate_lut (mode -> RATE, W) is natural; FSM and counters remain in sha3_msg_feeder.

Verification
REQ-026 sha3512, L=1280, 20 words -> 3 blocks, bitlen_o 576,576,128; din_valid_o counts 9,9,9; last block words 3-9 zero; done_o once.
REQ-027 shake128, L=1280 -> 1 block, bitlen_o=1280, 20 stream words + 1 zero word, 21 din_valid_o pulses.
REQ-028 sha3256, L=0 -> 1 block, bitlen_o=0, s_ready_o never 1, 17 zero words, done_o after valid_32_i.
REQ-029 sha3256, L=1088 -> blocks bitlen_o 1088 then 0; second block all-zero words.
REQ-030 sha3224, L=100, s_valid_i toggling every other cycle -> din_valid_o only on handshakes, word 1 bits 36-63 zero, 18 pulses total.
REQ-031 reset asserted at 5th word of LOAD -> next cycle IDLE, all core outputs 0, cmd_ready_o=1; following command completes normally.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared SHA-3 feeder constants: mode encodings, rate/word table, core length width.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sha3_pkg;

   localparam int SHA3_BITLEN_DEF = 11;
   localparam int RATE_W          = 11;
   localparam int WORDS_W         = 5;

   localparam logic [2:0] MODE_SHAKE128 = 3'd0;
   localparam logic [2:0] MODE_SHAKE256 = 3'd1;
   localparam logic [2:0] MODE_SHA3_512 = 3'd2;
   localparam logic [2:0] MODE_SHA3_384 = 3'd3;
   localparam logic [2:0] MODE_SHA3_256 = 3'd4;
   localparam logic [2:0] MODE_SHA3_224 = 3'd5;

   // Sponge rate in bits; unused encodings fall back to the 1088-bit rate.
   function automatic logic [RATE_W-1:0] rate_of(input logic [2:0] mode);
      case (mode)
         MODE_SHAKE128: rate_of = 11'd1344;
         MODE_SHAKE256: rate_of = 11'd1088;
         MODE_SHA3_512: rate_of = 11'd576;
         MODE_SHA3_384: rate_of = 11'd832;
         MODE_SHA3_256: rate_of = 11'd1088;
         MODE_SHA3_224: rate_of = 11'd1152;
         default:       rate_of = 11'd1088;
      endcase
   endfunction

   // Number of 64-bit words that make up one rate-sized block.
   function automatic logic [WORDS_W-1:0] words_of(input logic [2:0] mode);
      case (mode)
         MODE_SHAKE128: words_of = 5'd21;
         MODE_SHAKE256: words_of = 5'd17;
         MODE_SHA3_512: words_of = 5'd9;
         MODE_SHA3_384: words_of = 5'd13;
         MODE_SHA3_256: words_of = 5'd17;
         MODE_SHA3_224: words_of = 5'd18;
         default:       words_of = 5'd17;
      endcase
   endfunction

endpackage

// File: rtl/sha3_rate_lut.sv
// Mode to (rate bits, words per block) lookup.
// Latency: combinational, zero cycles.
// Backpressure: none.
module sha3_rate_lut
   import sha3_pkg::*;
(
   input  logic [2:0]         mode_i,
   output logic [RATE_W-1:0]  rate_o,
   output logic [WORDS_W-1:0] words_o
);

   // Pure table lookup from the shared package.
   always_comb begin
      rate_o  = rate_of(mode_i);
      words_o = words_of(mode_i);
   end

endmodule

// File: rtl/sha3_msg_feeder.sv
// Splits a bit-length-tagged message stream into rate-sized blocks and drives the SHA-3 core handshake.
// Latency: stream word to din64_o is combinational; one block = W beats plus the core start/busy exchange.
// Backpressure: s_ready_o only in LOAD while stream words remain; a missing word stalls din_valid_o.
module sha3_msg_feeder
   import sha3_pkg::*;
#(
   parameter int SHA3_BITLEN = SHA3_BITLEN_DEF
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [2:0]             mode_sel_i,
   input  logic [20:0]            msg_bitlen_i,
   input  logic                   s_valid_i,
   output logic                   s_ready_o,
   input  logic [0:63]            s_data_i,
   output logic [2:0]             mode_sel_o,
   output logic [0:63]            din64_o,
   output logic                   din_valid_o,
   output logic [SHA3_BITLEN-1:0] bitlen_o,
   output logic                   hash_ready_o,
   output logic                   start_o,
   output logic                   flag_o,
   input  logic                   core_ready_i,
   input  logic                   valid_32_i,
   output logic                   done_o
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_ARM      = 3'd2;
   localparam logic [2:0] S_START    = 3'd3;
   localparam logic [2:0] S_BUSY     = 3'd4;
   localparam logic [2:0] S_WAIT_OUT = 3'd5;
   localparam int         WL_W       = 16;

   logic [2:0]             state_q, state_d;
   logic [2:0]             mode_q, mode_d;
   logic [20:0]            rem_q, rem_d;
   logic [SHA3_BITLEN-1:0] bitlen_q, bitlen_d;
   logic                   last_q, last_d;
   logic [WL_W-1:0]        wleft_q, wleft_d;
   logic [5:0]             tail_q, tail_d;
   logic [WORDS_W-1:0]     wcnt_q, wcnt_d;
   logic                   done_q, done_d;

   logic [2:0]             lut_mode;
   logic [RATE_W-1:0]      rate;
   logic [WORDS_W-1:0]     words;
   logic [20:0]            blk_src, rate_ext, blk_rem;
   logic                   blk_full;
   logic [SHA3_BITLEN-1:0] blk_len;
   logic                   in_load, need_word, take, beat;
   logic [0:63]            keep_mask;

   // In IDLE the incoming command's mode sizes the first block; afterwards the latched mode does.
   assign lut_mode = (state_q == S_IDLE) ? mode_sel_i : mode_q;

   sha3_rate_lut u_rate_lut (
      .mode_i  (lut_mode),
      .rate_o  (rate),
      .words_o (words)
   );

   // Carve the next block from the remaining bit count: full rate block or the final (possibly empty) one.
   always_comb begin
      blk_src  = (state_q == S_IDLE) ? msg_bitlen_i : rem_q;
      rate_ext = 21'(rate);
      blk_full = (blk_src >= rate_ext);
      blk_rem  = blk_full ? (blk_src - rate_ext) : '0;
      blk_len  = blk_full ? SHA3_BITLEN'(rate) : SHA3_BITLEN'(blk_src);
   end

   // Stream-side datapath: pass real words on handshake, zero-fill once the stream is exhausted.
   always_comb begin
      in_load   = (state_q == S_LOAD);
      need_word = (wleft_q != '0);
      take      = in_load & need_word & s_valid_i;
      beat      = in_load & (need_word ? s_valid_i : 1'b1);
      if ((wleft_q == WL_W'(1)) && (tail_q != 6'd0)) begin
         keep_mask = ~({64{1'b1}} >> tail_q);
      end else begin
         keep_mask = {64{1'b1}};
      end
   end

   assign s_ready_o    = in_load & need_word;
   assign din_valid_o  = beat;
   assign din64_o      = take ? (s_data_i & keep_mask) : '0;
   assign cmd_ready_o  = (state_q == S_IDLE);
   assign hash_ready_o = (state_q == S_ARM) || (state_q == S_START) || (state_q == S_BUSY);
   assign start_o      = (state_q == S_START);
   assign flag_o       = (state_q == S_BUSY);
   assign mode_sel_o   = mode_q;
   assign bitlen_o     = bitlen_q;
   assign done_o       = done_q;

   // Block/handshake sequencing and counter updates.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      rem_d    = rem_q;
      bitlen_d = bitlen_q;
      last_d   = last_q;
      wleft_d  = wleft_q;
      tail_d   = tail_q;
      wcnt_d   = wcnt_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               mode_d   = mode_sel_i;
               rem_d    = blk_rem;
               bitlen_d = blk_len;
               last_d   = ~blk_full;
               wleft_d  = {1'b0, msg_bitlen_i[20:6]} + WL_W'(|msg_bitlen_i[5:0]);
               tail_d   = msg_bitlen_i[5:0];
               wcnt_d   = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (take) begin
               wleft_d = wleft_q - WL_W'(1);
            end
            if (beat) begin
               if (wcnt_q == (words - WORDS_W'(1))) begin
                  wcnt_d  = '0;
                  state_d = S_ARM;
               end else begin
                  wcnt_d = wcnt_q + WORDS_W'(1);
               end
            end
         end
         S_ARM: begin
            if (core_ready_i) state_d = S_START;
         end
         S_START: begin
            if (!core_ready_i) state_d = S_BUSY;
         end
         S_BUSY: begin
            if (core_ready_i) begin
               if (last_q) begin
                  state_d = S_WAIT_OUT;
               end else begin
                  rem_d    = blk_rem;
                  bitlen_d = blk_len;
                  last_d   = ~blk_full;
                  state_d  = S_LOAD;
               end
            end
         end
         S_WAIT_OUT: begin
            if (valid_32_i) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any partially fed block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mode_q   <= '0;
         rem_q    <= '0;
         bitlen_q <= '0;
         last_q   <= 1'b0;
         wleft_q  <= '0;
         tail_q   <= '0;
         wcnt_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         rem_q    <= rem_d;
         bitlen_q <= bitlen_d;
         last_q   <= last_d;
         wleft_q  <= wleft_d;
         tail_q   <= tail_d;
         wcnt_q   <= wcnt_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_sha3_msg_feeder.sv
// Directed bench for sha3_msg_feeder with hand-derived block lengths and word contents.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: stream valid held high or toggled per step; core ready driven per handshake step.
module tb_sha3_msg_feeder;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid_i, cmd_ready_o;
   logic [2:0]  mode_sel_i;
   logic [20:0] msg_bitlen_i;
   logic        s_valid_i, s_ready_o;
   logic [0:63] s_data_i;
   logic [2:0]  mode_sel_o;
   logic [0:63] din64_o;
   logic        din_valid_o;
   logic [10:0] bitlen_o;
   logic        hash_ready_o, start_o, flag_o;
   logic        core_ready_i, valid_32_i, done_o;

   int errors = 0;
   int checks = 0;
   int g      = 0;
   int cur_L  = 0;
   int cur_mode = 0;

   always #5 clk = ~clk;

   sha3_msg_feeder dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .mode_sel_i   (mode_sel_i),
      .msg_bitlen_i (msg_bitlen_i),
      .s_valid_i    (s_valid_i),
      .s_ready_o    (s_ready_o),
      .s_data_i     (s_data_i),
      .mode_sel_o   (mode_sel_o),
      .din64_o      (din64_o),
      .din_valid_o  (din_valid_o),
      .bitlen_o     (bitlen_o),
      .hash_ready_o (hash_ready_o),
      .start_o      (start_o),
      .flag_o       (flag_o),
      .core_ready_i (core_ready_i),
      .valid_32_i   (valid_32_i),
      .done_o       (done_o)
   );

   function automatic logic [0:63] pat(input int idx);
      logic [31:0] lo;
      lo = 32'hFFFF_FFFF - 32'(idx);
      return {16'hA5C3, idx[15:0], lo};
   endfunction

   // Expected word on the core bus for global stream slot idx of an L-bit message.
   function automatic logic [0:63] exp_word(input int idx, input int L);
      logic [0:63] w;
      int nw;
      int tail;
      nw   = (L + 63) / 64;
      tail = L % 64;
      if (idx >= nw) return '0;
      w = pat(idx);
      if ((idx == nw - 1) && (tail != 0)) begin
         for (int i = tail; i < 64; i++) w[i] = 1'b0;
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input int mode, input int L);
      cmd_valid_i  = 1'b1;
      mode_sel_i   = 3'(mode);
      msg_bitlen_i = 21'(L);
      cur_L        = L;
      cur_mode     = mode;
      g            = 0;
      #1;
      chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      #1;
      chk("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
   endtask

   // Feed one block; stop_after < w ends early without block-end checks.
   task automatic feed_block(input int w, input int exp_bitlen, input bit toggle,
                             input int stop_after, input bit expect_no_sready);
      int pulses      = 0;
      int stall_bad   = 0;
      int blen_bad    = 0;
      int sready_seen = 0;
      for (int cyc = 0; cyc < 400 && pulses < stop_after; cyc++) begin
         s_valid_i = toggle ? cyc[0] : 1'b1;
         s_data_i  = pat(g);
         #1;
         if (s_ready_o) sready_seen++;
         if (s_ready_o && !s_valid_i && din_valid_o) stall_bad++;
         if (int'(bitlen_o) != exp_bitlen) blen_bad++;
         if (din_valid_o) begin
            chk($sformatf("word_g%0d_slot%0d", g, pulses), 64'(din64_o), 64'(exp_word(g, cur_L)));
            pulses++;
         end
         if (s_ready_o && s_valid_i) g++;
         @(posedge clk); #1;
      end
      s_valid_i = 1'b0;
      #1;
      if (stop_after == w) begin
         chk("din_valid_pulses", 64'(pulses), 64'(w));
         chk("arm_after_block", 64'(hash_ready_o), 64'd1);
         chk("bitlen_stable_load", 64'(blen_bad), 64'd0);
         if (toggle) chk("stall_no_valid", 64'(stall_bad), 64'd0);
         if (expect_no_sready) chk("s_ready_never", 64'(sready_seen), 64'd0);
      end
   endtask

   task automatic core_hs(input bit last, input int exp_bitlen);
      core_ready_i = 1'b1;
      #1;
      chk("arm_start_low", 64'(start_o), 64'd0);
      @(posedge clk); #2;
      chk("start_high", 64'(start_o), 64'd1);
      chk("hash_ready_start", 64'(hash_ready_o), 64'd1);
      @(posedge clk); #2;
      chk("start_hold", 64'(start_o), 64'd1);
      core_ready_i = 1'b0;
      @(posedge clk); #2;
      chk("flag_high", 64'(flag_o), 64'd1);
      chk("start_low_busy", 64'(start_o), 64'd0);
      chk("bitlen_busy", 64'(bitlen_o), 64'(exp_bitlen));
      chk("mode_sel_busy", 64'(mode_sel_o), 64'(cur_mode));
      @(posedge clk); #1;
      core_ready_i = 1'b1;
      #1;
      chk("flag_hold", 64'(flag_o), 64'd1);
      @(posedge clk); #1;
      core_ready_i = 1'b0;
      #1;
      chk("flag_low_after", 64'(flag_o), 64'd0);
      chk("hash_ready_low_after", 64'(hash_ready_o), 64'd0);
      chk("more_blocks", 64'(din_valid_o | s_ready_o), 64'(!last));
   endtask

   task automatic finish_msg();
      #1;
      chk("done_early", 64'(done_o), 64'd0);
      chk("words_consumed", 64'(g), 64'((cur_L + 63) / 64));
      @(posedge clk); #1;
      valid_32_i = 1'b1;
      @(posedge clk); #1;
      valid_32_i = 1'b0;
      #1;
      chk("done_pulse", 64'(done_o), 64'd1);
      chk("cmd_ready_done", 64'(cmd_ready_o), 64'd1);
      @(posedge clk); #2;
      chk("done_single", 64'(done_o), 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"},  64'(cmd_ready_o),  64'd1);
      chk({tag, "_din_valid"},  64'(din_valid_o),  64'd0);
      chk({tag, "_s_ready"},    64'(s_ready_o),    64'd0);
      chk({tag, "_hash_ready"}, 64'(hash_ready_o), 64'd0);
      chk({tag, "_start"},      64'(start_o),      64'd0);
      chk({tag, "_flag"},       64'(flag_o),       64'd0);
      chk({tag, "_done"},       64'(done_o),       64'd0);
      chk({tag, "_bitlen"},     64'(bitlen_o),     64'd0);
      chk({tag, "_mode_sel"},   64'(mode_sel_o),   64'd0);
      chk({tag, "_din64"},      64'(din64_o),      64'd0);
   endtask

   initial begin
      reset        = 1'b1;
      cmd_valid_i  = 1'b1;
      mode_sel_i   = 3'd2;
      msg_bitlen_i = 21'd64;
      s_valid_i    = 1'b0;
      s_data_i     = '0;
      core_ready_i = 1'b0;
      valid_32_i   = 1'b0;

      // Reset with a command pending: the command must be dropped.
      repeat (2) @(posedge clk);
      #1;
      reset       = 1'b0;
      cmd_valid_i = 1'b0;
      #1;
      check_idle_outputs("reset");
      @(posedge clk); #2;
      chk("cmd_ignored_in_reset", 64'(s_ready_o | din_valid_o), 64'd0);
      @(posedge clk); #1;

      // sha3-512, 1280 bits: blocks 576, 576, 128; last block has 2 data words then 7 zero words.
      send_cmd(2, 1280);
      feed_block(9, 576, 1'b0, 9, 1'b0);
      core_hs(1'b0, 576);
      feed_block(9, 576, 1'b0, 9, 1'b0);
      core_hs(1'b0, 576);
      feed_block(9, 128, 1'b0, 9, 1'b0);
      core_hs(1'b1, 128);
      finish_msg();

      // shake128, 1280 bits: single 1280-bit block, 20 data words plus 1 zero word.
      send_cmd(0, 1280);
      feed_block(21, 1280, 1'b0, 21, 1'b0);
      core_hs(1'b1, 1280);
      finish_msg();

      // sha3-256, empty message: one zero-length block of 17 zero words, stream never asked.
      send_cmd(4, 0);
      feed_block(17, 0, 1'b0, 17, 1'b1);
      core_hs(1'b1, 0);
      finish_msg();

      // sha3-256, exactly one rate: full 1088-bit block then an empty all-zero block.
      send_cmd(4, 1088);
      feed_block(17, 1088, 1'b0, 17, 1'b0);
      core_hs(1'b0, 1088);
      feed_block(17, 0, 1'b0, 17, 1'b1);
      core_hs(1'b1, 0);
      finish_msg();

      // sha3-224, 100 bits with a gappy stream: word 1 bits 36..63 cleared, 18 beats.
      send_cmd(5, 100);
      feed_block(18, 100, 1'b1, 18, 1'b0);
      core_hs(1'b1, 100);
      finish_msg();

      // shake256 interrupted by reset while the 5th word is on the bus.
      send_cmd(1, 1088);
      feed_block(17, 1088, 1'b0, 4, 1'b0);
      s_valid_i = 1'b1;
      s_data_i  = pat(g);
      reset     = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      s_valid_i = 1'b0;
      #1;
      check_idle_outputs("midload_reset");
      @(posedge clk); #1;

      // Next command after the abort runs normally: sha3-384, 64 bits.
      send_cmd(3, 64);
      feed_block(13, 64, 1'b0, 13, 1'b0);
      core_hs(1'b1, 64);
      finish_msg();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
